afu_csr_mmio: RTL and testbench

//   MMIO CSR stage directly downstream of the CCI-P input buffering in ccip_std_afu.

---
 rtl/afu_csr_mmio.sv | 190 +++++++++++++++++++
 tb/tb_afu_csr_mmio.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/afu_csr_mmio.sv
// afu_csr_mmio: MMIO CSR block behind the CCI-P input buffers.
// Decodes c0 MMIO reads/writes, holds the AFU DFH/ID and control/status
// registers, and returns reads on c2 with a fixed two-cycle latency.
module afu_csr_mmio #(
  parameter logic [63:0] AFU_DFH  = 64'h1000_0000_0000_0000,
  parameter logic [63:0] AFU_ID_L = 64'h0,
  parameter logic [63:0] AFU_ID_H = 64'h0
) (
  input  logic        pClk,
  input  logic        pck_cp2af_softReset,
  input  logic        mmio_wr_valid,
  input  logic        mmio_rd_valid,
  input  logic [15:0] mmio_addr,
  input  logic [1:0]  mmio_len,
  input  logic [8:0]  mmio_tid,
  input  logic [63:0] mmio_wdata,
  output logic        mmio_rsp_valid,
  output logic [8:0]  mmio_rsp_tid,
  output logic [63:0] mmio_rsp_data,
  output logic        ctrl_start,
  output logic        ctrl_enable,
  output logic [63:0] buf_addr,
  input  logic        core_busy,
  input  logic        core_done,
  input  logic        core_error
);

  // 64-bit register indices (byte offset / 8)
  localparam logic [14:0] IDX_DFH     = 15'd0;
  localparam logic [14:0] IDX_ID_L    = 15'd1;
  localparam logic [14:0] IDX_ID_H    = 15'd2;
  localparam logic [14:0] IDX_SCRATCH = 15'd5;
  localparam logic [14:0] IDX_CTRL    = 15'd6;
  localparam logic [14:0] IDX_STATUS  = 15'd7;
  localparam logic [14:0] IDX_BUF     = 15'd8;
  localparam logic [14:0] IDX_CNT     = 15'd9;

  logic rst;
  assign rst = pck_cp2af_softReset;

  // A length code of 2 or 3 is not an access at all; a read that collides
  // with a write is discarded so the write always executes.
  logic        len_ok;
  logic        wide;
  logic        hi_half;
  logic [14:0] idx;
  logic        wr_req;
  logic        rd_req;

  assign len_ok  = ~mmio_len[1];
  assign wide    = mmio_len[0];
  assign hi_half = mmio_addr[0];
  assign idx     = mmio_addr[15:1];
  assign wr_req  = mmio_wr_valid & len_ok;
  assign rd_req  = mmio_rd_valid & ~mmio_wr_valid & len_ok;

  // Merge write data into a register honouring 32-bit half selection.
  function automatic logic [63:0] merge_write(input logic [63:0] cur,
                                              input logic [63:0] wdata,
                                              input logic        is_wide,
                                              input logic        hi);
    logic [63:0] res;
    if (is_wide)  res = wdata;
    else if (hi)  res = {wdata[31:0], cur[31:0]};
    else          res = {cur[63:32], wdata[31:0]};
    return res;
  endfunction

  // Size a 64-bit register value for the response: 32-bit reads return the
  // selected half right-justified with the upper word zeroed.
  function automatic logic [63:0] size_read(input logic [63:0] full,
                                            input logic        is_wide,
                                            input logic        hi);
    logic [63:0] res;
    if (is_wide)  res = full;
    else if (hi)  res = {32'b0, full[63:32]};
    else          res = {32'b0, full[31:0]};
    return res;
  endfunction

  logic [63:0] scratch;
  logic [63:0] buf_q;
  logic [63:0] cycle_cnt;
  logic        enable;
  logic        start;
  logic        done;
  logic        err;

  // Only a write touching CTRL's low word reaches the control bits.
  logic ctrl_lo_wr;
  logic clr_status;
  assign ctrl_lo_wr = wr_req & (idx == IDX_CTRL) & (wide | ~hi_half);
  assign clr_status = ctrl_lo_wr & mmio_wdata[1];

  // Writable registers and the one-cycle start pulse.
  always_ff @(posedge pClk) begin
    if (rst) begin
      scratch <= '0;
      buf_q   <= '0;
      enable  <= 1'b0;
      start   <= 1'b0;
    end else begin
      start <= ctrl_lo_wr & mmio_wdata[0];
      if (wr_req && idx == IDX_SCRATCH)
        scratch <= merge_write(scratch, mmio_wdata, wide, hi_half);
      if (wr_req && idx == IDX_BUF)
        buf_q <= merge_write(buf_q, mmio_wdata, wide, hi_half) & ~64'h3F;
      if (ctrl_lo_wr)
        enable <= mmio_wdata[2];
    end
  end

  // Sticky done/err flags; a set in the same cycle as a clear wins.
  always_ff @(posedge pClk) begin
    if (rst) begin
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      done <= core_done  | (done & ~clr_status);
      err  <= core_error | (err  & ~clr_status);
    end
  end

  // Free-running cycle counter, wraps naturally.
  always_ff @(posedge pClk) begin
    if (rst) cycle_cnt <= '0;
    else     cycle_cnt <= cycle_cnt + 64'd1;
  end

  // ---- stage p0: registered read request ----
  logic        vld_p0;
  logic [8:0]  tid_p0;
  logic [14:0] idx_p0;
  logic        wide_p0;
  logic        hi_p0;

  // Request valid is control and is cleared by reset, dropping in-flight reads.
  always_ff @(posedge pClk) begin
    if (rst) vld_p0 <= 1'b0;
    else     vld_p0 <= rd_req;
  end

  // Request payload travels with vld_p0 and needs no reset.
  always_ff @(posedge pClk) begin
    tid_p0  <= mmio_tid;
    idx_p0  <= idx;
    wide_p0 <= wide;
    hi_p0   <= hi_half;
  end

  // ---- stage p1: register mux into the response ----
  logic [63:0] full_p1;
  logic [63:0] data_p1;

  // Select the addressed register; unmapped offsets read zero.
  always_comb begin
    full_p1 = '0;
    case (idx_p0)
      IDX_DFH:     full_p1 = AFU_DFH;
      IDX_ID_L:    full_p1 = AFU_ID_L;
      IDX_ID_H:    full_p1 = AFU_ID_H;
      IDX_SCRATCH: full_p1 = scratch;
      IDX_CTRL:    full_p1 = {61'b0, enable, 2'b0};
      IDX_STATUS:  full_p1 = {61'b0, err, done, core_busy};
      IDX_BUF:     full_p1 = buf_q;
      IDX_CNT:     full_p1 = cycle_cnt;
      default:     full_p1 = '0;
    endcase
  end

  assign data_p1 = size_read(full_p1, wide_p0, hi_p0);

  // Registered c2 response; tid/data are zero whenever no response is valid.
  always_ff @(posedge pClk) begin
    if (rst) begin
      mmio_rsp_valid <= 1'b0;
      mmio_rsp_tid   <= '0;
      mmio_rsp_data  <= '0;
    end else begin
      mmio_rsp_valid <= vld_p0;
      mmio_rsp_tid   <= vld_p0 ? tid_p0  : 9'd0;
      mmio_rsp_data  <= vld_p0 ? data_p1 : 64'd0;
    end
  end

  assign ctrl_start  = start;
  assign ctrl_enable = enable;
  assign buf_addr    = buf_q;

endmodule

// File: tb/tb_afu_csr_mmio.sv
// Testbench for afu_csr_mmio: directed scenarios plus a randomized phase,
// all outputs compared every cycle against a register-map level model.
module tb_afu_csr_mmio;

  localparam logic [63:0] DFH  = 64'h1000_0000_0000_0000;
  localparam logic [63:0] ID_L = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] ID_H = 64'hFEDC_BA98_7654_3210;

  logic        pClk;
  logic        rst;
  logic        wr;
  logic        rd;
  logic [15:0] addr;
  logic [1:0]  len;
  logic [8:0]  tid;
  logic [63:0] wdata;
  logic        core_busy;
  logic        core_done;
  logic        core_error;
  logic        mmio_rsp_valid;
  logic [8:0]  mmio_rsp_tid;
  logic [63:0] mmio_rsp_data;
  logic        ctrl_start;
  logic        ctrl_enable;
  logic [63:0] buf_addr;

  afu_csr_mmio #(.AFU_DFH(DFH), .AFU_ID_L(ID_L), .AFU_ID_H(ID_H)) dut (
    .pClk                (pClk),
    .pck_cp2af_softReset (rst),
    .mmio_wr_valid       (wr),
    .mmio_rd_valid       (rd),
    .mmio_addr           (addr),
    .mmio_len            (len),
    .mmio_tid            (tid),
    .mmio_wdata          (wdata),
    .mmio_rsp_valid      (mmio_rsp_valid),
    .mmio_rsp_tid        (mmio_rsp_tid),
    .mmio_rsp_data       (mmio_rsp_data),
    .ctrl_start          (ctrl_start),
    .ctrl_enable         (ctrl_enable),
    .buf_addr            (buf_addr),
    .core_busy           (core_busy),
    .core_done           (core_done),
    .core_error          (core_error)
  );

  initial pClk = 1'b0;
  always #5 pClk = ~pClk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: architectural register contents.
  logic [63:0] m_scr, m_buf, m_cnt;
  logic        m_en, m_done, m_err;
  logic        pend_v;
  logic [15:0] pend_addr;
  logic [1:0]  pend_len;
  logic [8:0]  pend_tid;
  logic        e_rv;
  logic [8:0]  e_tid;
  logic [63:0] e_data;
  logic        e_start;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Value a read of byte offset 8*(a/2) returns, sized by l.
  function automatic logic [63:0] reg_val(input logic [15:0] a, input logic [1:0] l,
                                          input logic b);
    logic [63:0] full;
    int unsigned off;
    off = {16'b0, a};
    off = (off / 2) * 8;
    case (off)
      32'h00:  full = DFH;
      32'h08:  full = ID_L;
      32'h10:  full = ID_H;
      32'h28:  full = m_scr;
      32'h30:  full = {61'b0, m_en, 2'b0};
      32'h38:  full = {61'b0, m_err, m_done, b};
      32'h40:  full = m_buf;
      32'h48:  full = m_cnt;
      default: full = 64'd0;
    endcase
    if (l == 2'd1) return full;
    return a[0] ? (full >> 32) : (full & 64'hFFFF_FFFF);
  endfunction

  function automatic logic [63:0] put(input logic [63:0] cur, input logic [63:0] wd,
                                      input logic [15:0] a, input logic [1:0] l);
    if (l == 2'd1) return wd;
    return a[0] ? {wd[31:0], cur[31:0]} : {cur[63:32], wd[31:0]};
  endfunction

  // Advance the model by one clock using the inputs the DUT just sampled.
  task automatic model_edge();
    logic w, r, clr;
    int unsigned off;
    if (rst) begin
      m_scr = 0; m_buf = 0; m_cnt = 0; m_en = 0; m_done = 0; m_err = 0;
      pend_v = 0; e_rv = 0; e_tid = 0; e_data = 0; e_start = 0;
      return;
    end
    e_rv   = pend_v;
    e_tid  = pend_v ? pend_tid : 9'd0;
    e_data = pend_v ? reg_val(pend_addr, pend_len, core_busy) : 64'd0;
    w = wr && (len < 2'd2);
    r = rd && !wr && (len < 2'd2);
    e_start = 0;
    clr = 0;
    if (w) begin
      off = {16'b0, addr};
      off = (off / 2) * 8;
      if (off == 32'h28) m_scr = put(m_scr, wdata, addr, len);
      if (off == 32'h40) m_buf = put(m_buf, wdata, addr, len) & ~64'h3F;
      if (off == 32'h30 && (len == 2'd1 || !addr[0])) begin
        e_start = wdata[0];
        clr     = wdata[1];
        m_en    = wdata[2];
      end
    end
    m_done = core_done  | (m_done & !clr);
    m_err  = core_error | (m_err  & !clr);
    m_cnt  = m_cnt + 64'd1;
    pend_v = r; pend_addr = addr; pend_len = len; pend_tid = tid;
  endtask

  task automatic tick();
    @(posedge pClk);
    model_edge();
    #1;
    chk("rsp_valid",   {63'b0, mmio_rsp_valid}, {63'b0, e_rv});
    chk("rsp_tid",     {55'b0, mmio_rsp_tid},   {55'b0, e_tid});
    chk("rsp_data",    mmio_rsp_data,           e_data);
    chk("ctrl_start",  {63'b0, ctrl_start},     {63'b0, e_start});
    chk("ctrl_enable", {63'b0, ctrl_enable},    {63'b0, m_en});
    chk("buf_addr",    buf_addr,                m_buf);
  endtask

  task automatic idle();
    wr = 0; rd = 0; addr = 0; len = 2'd1; tid = 0; wdata = 0;
    core_done = 0; core_error = 0;
  endtask

  task automatic set_rd(input logic [15:0] a, input logic [1:0] l, input logic [8:0] t);
    idle(); rd = 1; addr = a; len = l; tid = t;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [1:0] l, input logic [63:0] d);
    idle(); wr = 1; addr = a; len = l; wdata = d;
    tick();
    idle();
  endtask

  task automatic do_read(input logic [15:0] a, input logic [1:0] l, input logic [8:0] t,
                         output logic v, output logic [63:0] d);
    set_rd(a, l, t);
    tick();
    idle();
    tick();
    v = mmio_rsp_valid;
    d = mmio_rsp_data;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        v;
    logic [63:0] d, c1, c2;
    idle();
    core_busy = 0;
    rst = 1;
    repeat (3) tick();
    rst = 0;
    chk("reset_rsp_valid", {63'b0, mmio_rsp_valid}, 64'd0);
    chk("reset_start",     {63'b0, ctrl_start},     64'd0);
    chk("reset_buf",       buf_addr,                64'd0);

    // Back-to-back ID reads
    set_rd(16'h0, 2'd1, 9'd5); tick();
    set_rd(16'h2, 2'd1, 9'd6); tick();
    chk("b2b_dfh", mmio_rsp_data, DFH);
    chk("b2b_tid5", {55'b0, mmio_rsp_tid}, 64'd5);
    set_rd(16'h4, 2'd1, 9'd7); tick();
    chk("b2b_idl", mmio_rsp_data, ID_L);
    chk("b2b_tid6", {55'b0, mmio_rsp_tid}, 64'd6);
    idle(); tick();
    chk("b2b_idh", mmio_rsp_data, ID_H);
    chk("b2b_tid7", {55'b0, mmio_rsp_tid}, 64'd7);
    tick();
    chk("b2b_quiet", {63'b0, mmio_rsp_valid}, 64'd0);

    // SCRATCH with a 32-bit upper-half write
    do_write(16'hA, 2'd1, 64'hDEAD_BEEF_0123_4567);
    do_write(16'hB, 2'd0, 64'h0000_0000_CAFE_F00D);
    do_read(16'hA, 2'd1, 9'd1, v, d);
    chk("scr64_valid", {63'b0, v}, 64'd1);
    chk("scr64", d, 64'hCAFE_F00D_0123_4567);
    do_read(16'hB, 2'd0, 9'd2, v, d);
    chk("scr32_hi", d, 64'h0000_0000_CAFE_F00D);

    // CTRL start/enable
    do_write(16'hC, 2'd1, 64'h5);
    chk("start_pulse", {63'b0, ctrl_start}, 64'd1);
    chk("enable_set",  {63'b0, ctrl_enable}, 64'd1);
    tick();
    chk("start_gone",  {63'b0, ctrl_start}, 64'd0);
    do_read(16'hC, 2'd1, 9'd3, v, d);
    chk("ctrl_read", d, 64'h4);

    // STATUS sticky bits and clear-vs-set priority
    idle(); core_done = 1; tick(); idle();
    do_read(16'hE, 2'd1, 9'd4, v, d);
    chk("status_done", d, 64'h2);
    idle(); wr = 1; addr = 16'hC; len = 2'd1; wdata = 64'h6; core_error = 1;
    tick(); idle();
    do_read(16'hE, 2'd1, 9'd8, v, d);
    chk("status_clr_set", d, 64'h4);

    // BUF_ADDR alignment, unmapped read, cycle counter
    do_write(16'h10, 2'd1, 64'h1234_567F);
    chk("buf_align", buf_addr, 64'h1234_5640);
    do_read(16'h20, 2'd1, 9'd9, v, d);
    chk("unmapped_valid", {63'b0, v}, 64'd1);
    chk("unmapped", d, 64'd0);
    set_rd(16'h12, 2'd1, 9'd10); tick();
    set_rd(16'h12, 2'd1, 9'd11); tick();
    c1 = mmio_rsp_data;
    idle(); tick();
    c2 = mmio_rsp_data;
    chk("cnt_delta", c2 - c1, 64'd1);

    // Simultaneous read and write: write lands, read dropped
    idle(); wr = 1; rd = 1; addr = 16'hA; len = 2'd1; wdata = 64'h77; tid = 9'd12;
    tick(); idle(); tick();
    chk("rdwr_dropped", {63'b0, mmio_rsp_valid}, 64'd0);
    do_read(16'hA, 2'd1, 9'd13, v, d);
    chk("rdwr_written", d, 64'h77);

    // Reset with a read in flight
    set_rd(16'h0, 2'd1, 9'd14); tick();
    idle(); rst = 1; tick(); rst = 0;
    chk("inflight_drop", {63'b0, mmio_rsp_valid}, 64'd0);
    tick();
    chk("inflight_drop2", {63'b0, mmio_rsp_valid}, 64'd0);
    do_read(16'hA, 2'd1, 9'd15, v, d);  chk("post_rst_scr", d, 64'd0);
    do_read(16'hC, 2'd1, 9'd16, v, d);  chk("post_rst_ctrl", d, 64'd0);
    do_read(16'hE, 2'd1, 9'd17, v, d);  chk("post_rst_status", d, 64'd0);
    do_read(16'h10, 2'd1, 9'd18, v, d); chk("post_rst_buf", d, 64'd0);
    do_read(16'h0, 2'd1, 9'd19, v, d);  chk("post_rst_dfh", d, DFH);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst   = ($urandom_range(0, 99) == 0);
      wr    = ($urandom_range(0, 3) == 0);
      rd    = ($urandom_range(0, 1) == 1);
      addr  = {11'b0, 5'($urandom_range(0, 21))};
      if ($urandom_range(0, 9) == 0) addr = 16'($urandom);
      len   = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      tid   = 9'($urandom);
      wdata = {$urandom, $urandom};
      core_busy  = 1'($urandom_range(0, 1));
      core_done  = ($urandom_range(0, 7) == 0);
      core_error = ($urandom_range(0, 7) == 0);
      tick();
    end
    rst = 0;
    idle();
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
